// File: rtl/wb_burst_reader.sv
// Wishbone pipelined-read burst master with a first-word-fall-through output buffer.
// Define WB_READER_TIMEOUT_EN to add an ack watchdog that aborts a stuck burst and raises err.
module wb_burst_reader #(
  parameter int AW    = 16,
  parameter int DW    = 16,
  parameter int LW    = 8,
  parameter int DEPTH = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic [AW-1:0] base,
  input  logic [LW-1:0] len,
  output logic          busy,
  output logic          done,
  output logic          err,
  output logic [DW-1:0] rd_data,
  output logic          rd_valid,
  input  logic          rd_ready,
  output logic          wb_cyc_o,
  output logic          wb_stb_o,
  output logic          wb_we_o,
  output logic [AW-1:0] wb_adr_o,
  input  logic [DW-1:0] wb_dat_i,
  input  logic          wb_ack_i,
  input  logic          wb_stall_i
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW:0] DEPTH_L = (CW+1)'(DEPTH);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_REQ  = 2'd1;
  localparam logic [1:0] S_WAIT = 2'd2;

  logic [1:0]    state_q, state_d;
  logic [AW-1:0] adr_q, adr_d;
  logic [LW:0]   req_left_q, req_left_d;
  logic [LW:0]   ack_left_q, ack_left_d;
  logic [CW-1:0] out_q, out_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [PW-1:0] wptr_q, wptr_d;
  logic [PW-1:0] rptr_q, rptr_d;
  logic          cyc_q, cyc_d;
  logic          stb_q, stb_d;
  logic          done_q, done_d;
  logic          err_q, err_d;
  logic [DW-1:0] mem_q [DEPTH];

  logic start_ok, accept, ack_v, pop, last_ack, abort;

  assign start_ok = start & (state_q == S_IDLE);
  assign accept   = stb_q & ~wb_stall_i;
  // Acks with nothing outstanding (stray or after an abort) never reach the buffer.
  assign ack_v    = wb_ack_i & (out_q != '0);
  assign pop      = (cnt_q != '0) & rd_ready;
  assign last_ack = ack_v & (ack_left_q == (LW+1)'(1));

`ifdef WB_READER_TIMEOUT_EN
  logic [7:0] wdog_q, wdog_d;

  always_comb begin
    wdog_d = wdog_q;
    if (start_ok || wb_ack_i || abort) wdog_d = '0;
    else if (cyc_q)                    wdog_d = wdog_q + 8'd1;
  end

  // The edge that would take the count to 255 is the abort edge.
  assign abort = cyc_q & ~wb_ack_i & (wdog_q == 8'd254);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) wdog_q <= '0;
    else        wdog_q <= wdog_d;
  end
`else
  assign abort = 1'b0;
`endif

  always_comb begin
    state_d    = state_q;
    adr_d      = accept ? adr_q + AW'(1) : adr_q;
    req_left_d = req_left_q - (LW+1)'(accept);
    ack_left_d = ack_left_q - (LW+1)'(ack_v);
    out_d      = out_q + CW'(accept) - CW'(ack_v);
    cnt_d      = cnt_q + CW'(ack_v) - CW'(pop);
    wptr_d     = wptr_q + PW'(ack_v);
    rptr_d     = rptr_q + PW'(pop);
    done_d     = 1'b0;
    err_d      = err_q;
    case (state_q)
      S_IDLE: begin
        if (start_ok) begin
          err_d = 1'b0;
          if (len != '0) begin
            state_d    = S_REQ;
            adr_d      = base;
            req_left_d = {1'b0, len};
            ack_left_d = {1'b0, len};
          end else begin
            done_d = 1'b1;
          end
        end
      end
      S_REQ: if (accept && req_left_q == (LW+1)'(1)) state_d = S_WAIT;
      S_WAIT: begin
        if (last_ack) begin
          state_d = S_IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
    if (abort) begin
      state_d    = S_IDLE;
      done_d     = 1'b1;
      err_d      = 1'b1;
      out_d      = '0;
      req_left_d = '0;
      ack_left_d = '0;
    end
    cyc_d = (state_d != S_IDLE);
    // Credit: buffered words plus in-flight requests (including one accepted now) must leave room.
    stb_d = (state_d == S_REQ) && (req_left_d != '0) &&
            (({1'b0, cnt_d} + {1'b0, out_d}) < DEPTH_L);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      adr_q      <= '0;
      req_left_q <= '0;
      ack_left_q <= '0;
      out_q      <= '0;
      cnt_q      <= '0;
      wptr_q     <= '0;
      rptr_q     <= '0;
      cyc_q      <= 1'b0;
      stb_q      <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      adr_q      <= adr_d;
      req_left_q <= req_left_d;
      ack_left_q <= ack_left_d;
      out_q      <= out_d;
      cnt_q      <= cnt_d;
      wptr_q     <= wptr_d;
      rptr_q     <= rptr_d;
      cyc_q      <= cyc_d;
      stb_q      <= stb_d;
      done_q     <= done_d;
      err_q      <= err_d;
    end
  end

  always_ff @(posedge clk) begin
    if (ack_v) mem_q[wptr_q] <= wb_dat_i;
  end

  assign busy     = (state_q != S_IDLE);
  assign done     = done_q;
  assign err      = err_q;
  assign wb_cyc_o = cyc_q;
  assign wb_stb_o = stb_q;
  assign wb_we_o  = 1'b0;
  assign wb_adr_o = adr_q;
  assign rd_valid = (cnt_q != '0);
  assign rd_data  = rd_valid ? mem_q[rptr_q] : '0;

endmodule

// File: tb/tb_wb_burst_reader.sv
// Directed bench for wb_burst_reader with a pipelined Wishbone slave returning addr ^ 16'hA5A5.
module tb_wb_burst_reader;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [15:0] base;
  logic [7:0]  len;
  logic        busy, done, err;
  logic [15:0] rd_data;
  logic        rd_valid;
  logic        rd_ready;
  logic        wb_cyc_o, wb_stb_o, wb_we_o;
  logic [15:0] wb_adr_o;
  logic [15:0] wb_dat_i = '0;
  logic        wb_ack_i = 1'b0;
  logic        wb_stall_i = 1'b0;

  int total = 0;
  int bad   = 0;

  logic        ack_en = 1'b1;
  logic [15:0] stall_adr = 16'h0000;
  int          stall_left = 0;
  logic        s_acc;
  logic [15:0] s_adr;

  logic [15:0] adr_log[$];
  logic [15:0] pop_log[$];
  int cyc_cnt, stb_cnt, done_cnt, hold_cnt;

  wb_burst_reader dut (
    .clk(clk), .rst_n(rst_n), .start(start), .base(base), .len(len),
    .busy(busy), .done(done), .err(err),
    .rd_data(rd_data), .rd_valid(rd_valid), .rd_ready(rd_ready),
    .wb_cyc_o(wb_cyc_o), .wb_stb_o(wb_stb_o), .wb_we_o(wb_we_o),
    .wb_adr_o(wb_adr_o), .wb_dat_i(wb_dat_i),
    .wb_ack_i(wb_ack_i), .wb_stall_i(wb_stall_i)
  );

  always #5 clk = ~clk;

  // Slave: ack one cycle after acceptance; optional stall on one address.
  always @(posedge clk) begin
    s_acc = wb_cyc_o & wb_stb_o & ~wb_stall_i;
    s_adr = wb_adr_o;
    #1;
    wb_ack_i   = s_acc & ack_en;
    wb_dat_i   = s_adr ^ 16'hA5A5;
    wb_stall_i = wb_stb_o && (wb_adr_o == stall_adr) && (stall_left > 0);
    if (wb_stall_i) stall_left = stall_left - 1;
  end

  always @(negedge clk) begin
    if (wb_cyc_o) cyc_cnt++;
    if (wb_stb_o) stb_cnt++;
    if (wb_stb_o && !wb_stall_i) adr_log.push_back(wb_adr_o);
    if (wb_stb_o && wb_adr_o == 16'h0201) hold_cnt++;
    if (rd_valid && rd_ready) pop_log.push_back(rd_data);
    if (done) done_cnt++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic clear_logs();
    adr_log.delete();
    pop_log.delete();
    cyc_cnt = 0; stb_cnt = 0; done_cnt = 0; hold_cnt = 0;
  endtask

  task automatic kick(input logic [15:0] b, input logic [7:0] l);
    start = 1'b1; base = b; len = l;
    step();
    start = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int maxc);
    int n = 0;
    while (!done && n < maxc) begin
      step();
      n++;
    end
    check(tag, 32'(done), 32'd1);
  endtask

  task automatic check_burst(input string tag, input logic [15:0] first, input int n);
    logic [15:0] a;
    check({tag, "_nreq"}, 32'(adr_log.size()), 32'(n));
    check({tag, "_npop"}, 32'(pop_log.size()), 32'(n));
    for (int i = 0; i < n; i++) begin
      a = first + 16'(i);
      check($sformatf("%s_adr%0d", tag, i), 32'(adr_log[i]), 32'(a));
      check($sformatf("%s_dat%0d", tag, i), 32'(pop_log[i]), 32'(a ^ 16'hA5A5));
    end
  endtask

  initial begin
    #100000;
    $display("FAIL global_timeout got=running exp=finished");
    $fatal(1, "timeout");
  end

  initial begin
    rst_n = 1'b0; start = 1'b0; base = '0; len = '0; rd_ready = 1'b1;
    step(); step();
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_err",  32'(err), 32'd0);
    check("rst_cyc",  32'(wb_cyc_o), 32'd0);
    check("rst_stb",  32'(wb_stb_o), 32'd0);
    check("rst_we",   32'(wb_we_o), 32'd0);
    check("rst_adr",  32'(wb_adr_o), 32'd0);
    check("rst_vld",  32'(rd_valid), 32'd0);
    check("rst_dat",  32'(rd_data), 32'd0);
    rst_n = 1'b1;
    step();

    // Basic 4-word burst, zero stall.
    clear_logs();
    kick(16'h0100, 8'd4);
    check("t1_cyc1", 32'(wb_cyc_o), 32'd1);
    check("t1_stb1", 32'(wb_stb_o), 32'd1);
    check("t1_adr1", 32'(wb_adr_o), 32'h0100);
    check("t1_busy", 32'(busy), 32'd1);
    wait_done("t1_done", 50);
    check("t1_busy_end", 32'(busy), 32'd0);
    check("t1_cyc_end", 32'(wb_cyc_o), 32'd0);
    step();
    check("t1_done_fall", 32'(done), 32'd0);
    repeat (4) step();
    check_burst("t1", 16'h0100, 4);
    check("t1_stbcnt", 32'(stb_cnt), 32'd4);
    check("t1_cyccnt", 32'(cyc_cnt), 32'd5);
    check("t1_donecnt", 32'(done_cnt), 32'd1);
    check("t1_err", 32'(err), 32'd0);

    // Credit limit with a stalled consumer.
    clear_logs();
    rd_ready = 1'b0;
    kick(16'h0300, 8'd8);
    repeat (10) step();
    check("t2_nreq_full", 32'(adr_log.size()), 32'd4);
    check("t2_stb_low", 32'(wb_stb_o), 32'd0);
    check("t2_vld", 32'(rd_valid), 32'd1);
    check("t2_head", 32'(rd_data), 32'hA6A5);
    rd_ready = 1'b1;
    wait_done("t2_done", 100);
    repeat (6) step();
    check_burst("t2", 16'h0300, 8);

    // Slave stall on the second request.
    clear_logs();
    stall_adr = 16'h0201; stall_left = 3;
    kick(16'h0200, 8'd4);
    wait_done("t3_done", 50);
    repeat (4) step();
    check("t3_hold", 32'(hold_cnt), 32'd4);
    check_burst("t3", 16'h0200, 4);

    // Address wrap.
    clear_logs();
    kick(16'hFFFE, 8'd4);
    wait_done("t4_done", 50);
    repeat (4) step();
    check_burst("t4", 16'hFFFE, 4);

    // Zero length.
    clear_logs();
    kick(16'h0050, 8'd0);
    check("t4z_done", 32'(done), 32'd1);
    check("t4z_busy", 32'(busy), 32'd0);
    step();
    check("t4z_done_fall", 32'(done), 32'd0);
    repeat (3) step();
    check("t4z_cyccnt", 32'(cyc_cnt), 32'd0);

    // Start while busy is ignored.
    clear_logs();
    kick(16'h0400, 8'd3);
    kick(16'h0500, 8'd5);
    wait_done("t4b_done", 50);
    repeat (4) step();
    check_burst("t4b", 16'h0400, 3);
    check("t4b_donecnt", 32'(done_cnt), 32'd1);

    // Reset mid-burst after two acks.
    clear_logs();
    rd_ready = 1'b0;
    kick(16'h0600, 8'd6);
    repeat (3) step();
    check("t5_pre_vld", 32'(rd_valid), 32'd1);
    rst_n = 1'b0;
    #1;
    check("t5_cyc", 32'(wb_cyc_o), 32'd0);
    check("t5_stb", 32'(wb_stb_o), 32'd0);
    check("t5_busy", 32'(busy), 32'd0);
    check("t5_vld", 32'(rd_valid), 32'd0);
    check("t5_dat", 32'(rd_data), 32'd0);
    check("t5_adr", 32'(wb_adr_o), 32'd0);
    step(); step();
    rst_n = 1'b1;
    rd_ready = 1'b1;
    step();
    clear_logs();
    kick(16'h0700, 8'd2);
    wait_done("t5_done", 50);
    repeat (4) step();
    check_burst("t5", 16'h0700, 2);

`ifdef WB_READER_TIMEOUT_EN
    // Slave never acks: watchdog abort.
    clear_logs();
    ack_en = 1'b0;
    kick(16'h0800, 8'd2);
    wait_done("t6_done", 400);
    check("t6_err", 32'(err), 32'd1);
    check("t6_cyc", 32'(wb_cyc_o), 32'd0);
    check("t6_busy", 32'(busy), 32'd0);
    repeat (3) step();
    check("t6_cyccnt", 32'(cyc_cnt), 32'd255);
    check("t6_donecnt", 32'(done_cnt), 32'd1);
    check("t6_err_sticky", 32'(err), 32'd1);
    ack_en = 1'b1;
    clear_logs();
    kick(16'h0900, 8'd1);
    check("t6_err_clr", 32'(err), 32'd0);
    wait_done("t6b_done", 50);
    repeat (3) step();
    check_burst("t6b", 16'h0900, 1);
`else
    check("t6_err_tied", 32'(err), 32'd0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/wb_burst_reader.md
# wb_burst_reader

Wishbone pipelined-read master that fetches a block of consecutive words from a Wishbone slave (ROM, RAM) and delivers them in order on a first-word-fall-through stream port. It sits between a local consumer (loader, prefetcher, debug dump) and the shared Wishbone bus. It limits outstanding requests so returned data can never overflow its internal buffer.

## Interface
- `AW`, 16, address width (word address)
- `DW`, 16, data width
- `LW`, 8, width of the burst length field
- `DEPTH`, 4, buffer entries; power of two, ≥2

- `clk`  in  1  clock
- `rst_n`  in  1  asynchronous, active-low reset
- `start`  in  1  start pulse; accepted only when `busy`=0
- `base`  in  AW  first word address, sampled with `start`
- `len`  in  LW  words to read, sampled with `start`
- `busy`  out  1  burst in progress
- `done`  out  1  one-cycle pulse at burst end
- `err`  out  1  burst aborted by timeout
- `rd_data`  out  DW  head-of-buffer word
- `rd_valid`  out  1  `rd_data` valid
- `rd_ready`  in  1  consumer pops when `rd_valid`&`rd_ready`
- `wb_cyc_o`, `wb_stb_o`, `wb_we_o`  out  1  Wishbone control; `wb_we_o` is constant 0
- `wb_adr_o`  out  AW  request address
- `wb_dat_i`  in  DW  read data
- `wb_ack_i`, `wb_stall_i`  in  1  slave ack and stall

## Operation
- Reset: all outputs 0, buffer empty, FSM in IDLE.
- FSM states:
  - IDLE: on `start` with `len`≠0, load `base`, `len` and go to REQ.
  - REQ: issue requests, then go to WAIT after the last request is accepted.
  - WAIT: when the last ack arrives, go to IDLE and pulse `done`.
- `start` with `len`=0: `done` pulses the next cycle. No bus cycle is issued and `busy` stays 0.
- Request acceptance:
  - A request is accepted on a clock edge where `wb_stb_o`&~`wb_stall_i`.
  - `wb_adr_o` then increments by 1 modulo 2^AW.
  - While stalled, `wb_adr_o` and `wb_stb_o` hold.
- Credit rule: `wb_stb_o` asserts only when buffer occupancy + outstanding requests < `DEPTH`. Count a request accepted this edge as outstanding.
- Acks:
  - Each `wb_ack_i` while outstanding>0 writes `wb_dat_i` into the buffer and decrements outstanding.
  - An ack with outstanding=0 is ignored.
- `wb_cyc_o` is high from the first request until the cycle after the last ack.
- `busy` equals (state≠IDLE).
- `start` while `busy`=1 is ignored.
- Buffer:
  - Simultaneous write and pop are both honoured.
  - Data leaves strictly in address order.
  - Words remaining after `done` stay poppable.
- Counters are LW+1 bits wide, so `len`=2^LW−1 is legal.
- Reset asserted mid-burst: immediate return to reset values. This drops `wb_cyc_o`/`wb_stb_o` asynchronously and discards buffered data.

## Timing
- `start` at edge 0 gives `wb_cyc_o`/`wb_stb_o`/`wb_adr_o`=`base` registered after edge 0, so they are visible in cycle 1.
- With a zero-stall slave acking one cycle after acceptance, and `rd_ready`=1, the master sustains one request and one word per cycle.
- Ack sampled at edge N gives the word at buffer head with `rd_valid`=1 after edge N (registered write).
- Last ack sampled at edge N: `wb_cyc_o`=0, `busy`=0 and `done`=1 after edge N. `done` falls after edge N+1.
- `err` is cleared by the next accepted `start`.

## Configuration
- `WB_READER_TIMEOUT_EN`:
  - Defined: an 8-bit watchdog counts cycles with `wb_cyc_o`=1 and no `wb_ack_i`. It clears on every ack and on `start`.
  - When the count reaches 255, the burst aborts: `wb_cyc_o`/`wb_stb_o` drop, the FSM goes to IDLE, `done` pulses and `err`=1. `err` is sticky.
  - Already-buffered words remain poppable. Late acks are ignored.
  - Undefined: no watchdog, and `err` is tied to 0.

## Test plan
- `base`=0x0100, `len`=4, zero-stall slave, `rd_ready`=1:
  - `wb_adr_o` 0x0100..0x0103 on 4 consecutive cycles, with `wb_stb_o` high for 4 cycles.
  - 4 words out in order, `wb_cyc_o` high for 5 cycles, exactly one `done`.
- `DEPTH`=4, `len`=8, `rd_ready`=0:
  - `wb_stb_o` drops after 4 accepted requests.
  - After raising `rd_ready`, the remaining 4 are issued and all 8 words arrive in order, with none lost or duplicated.
- `wb_stall_i` high for 3 cycles during the second request of `len`=4 from 0x0200: `wb_adr_o` holds 0x0201 for 4 cycles, no skipped or repeated address, 4 words delivered.
- `base`=0xFFFE, `len`=4: addresses 0xFFFE, 0xFFFF, 0x0000, 0x0001. Also `len`=0 gives `done` next cycle with no `wb_cyc_o`, and a second `start` mid-burst changes nothing.
- `rst_n` low after 2 of 6 acks: all outputs 0 immediately, `rd_valid`=0. A new `start` then runs normally.
- With `WB_READER_TIMEOUT_EN`, slave never acks: abort 255 cycles after `wb_cyc_o` rises, with `err`=1, one `done` and `wb_cyc_o`=0.
